// File: rtl/reg_fifo_arb.sv
// Round-robin burst arbiter feeding a single register FIFO write port.
// The owner bursts until reqLast, MAXBURST beats, or it drops req; fifoFull stalls the burst.
module reg_fifo_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAXBURST = 4
) (
  input  logic               clockCore,
  input  logic               resetCore,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] reqData,
  input  logic [NREQ-1:0]    reqLast,
  output logic [NREQ-1:0]    ack,
  output logic               fifoPush,
  output logic [DW-1:0]      fifoDataIn,
  input  logic               fifoFull,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               pushErr
);

  localparam int unsigned CW = $clog2(MAXBURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [CW-1:0]   beat_cnt;
  logic [2:0]      winner;
  logic [2:0]      idx;
  logic            any_req;
  logic [7:0]      req_ext;
  logic [7:0]      last_ext;
  logic [7:0]      ack_ext;
  logic [DW-1:0]   data_arr [8];
  logic            owner_req;
  logic            owner_last;
  logic            burst_end;

  // Widen per-requester vectors to the 3-bit owner index space
  always_comb begin
    req_ext  = 8'(req);
    last_ext = 8'(reqLast);
    for (int unsigned i = 0; i < 8; i++) begin
      data_arr[i] = '0;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = reqData[i*DW +: DW];
    end
  end

  // Round-robin search starting at ptr+1; descending loop so the nearest hit wins
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      idx = 3'((32'(ptr) + i) % NREQ);
      if (req_ext[idx]) begin
        winner = idx;
      end
    end
  end

  assign owner_req  = req_ext[owner];
  assign owner_last = last_ext[owner];
  assign fifoPush   = (state == BURST) && owner_req && !fifoFull && !resetCore;
  assign fifoDataIn = data_arr[owner];
  assign busy       = (state == BURST);
  assign burst_end  = !owner_req ||
                      (fifoPush && (owner_last || beat_cnt == CW'(MAXBURST - 1)));

  always_comb begin
    ack_ext        = '0;
    ack_ext[owner] = fifoPush;
    ack            = ack_ext[NREQ-1:0];
  end

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= 3'(NREQ - 1);
      beat_cnt <= '0;
      pushErr  <= 1'b0;
    end else begin
      if (fifoPush && fifoFull) begin
        pushErr <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_req && !fifoFull) begin
            owner    <= winner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          // Previous owner becomes lowest priority for the next arbitration
          if (burst_end) begin
            state <= IDLE;
            ptr   <= owner;
          end else if (fifoPush) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
